// File: rtl/pipeline_pkg.sv
// Shared types for the RAT core hazard/flush controller: decode classes and FSM states.
// No timing of its own; helpers are elaborated at compile time.
package pipeline_pkg;

  typedef enum logic [3:0] {
    TYPE_BRANCH_LO = 4'd1,
    TYPE_BRANCH_HI = 4'd5,
    TYPE_CALL      = 4'd6,
    TYPE_RET_LO    = 4'd7,
    TYPE_RET_HI    = 4'd9
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_RETURN = 2'd2,
    ST_FLUSH  = 2'd3
  } hazard_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/raw_detect.sv
// Read-after-write comparator of decode sources against the EX and WB destinations.
// Purely combinational, zero latency; never stalls, it only reports.
module raw_detect #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] reg_a,
  input  logic [REG_AW-1:0] reg_b,
  input  logic              a_read,
  input  logic              b_read,
  input  logic [REG_AW-1:0] reg_ex,
  input  logic [REG_AW-1:0] reg_wb,
  input  logic              reg_ex_en,
  input  logic              reg_wb_en,
  output logic              raw_ex,
  output logic              raw_wb,
  output logic              fwd_a_sel,
  output logic              fwd_b_sel
);

  logic a_hits_wb;
  logic b_hits_wb;

  assign raw_ex = reg_ex_en && ((a_read && (reg_a == reg_ex)) || (b_read && (reg_b == reg_ex)));

  assign a_hits_wb = reg_wb_en && a_read && (reg_a == reg_wb);
  assign b_hits_wb = reg_wb_en && b_read && (reg_b == reg_wb);
  assign raw_wb    = a_hits_wb || b_hits_wb;

  // A pending EX write is younger than WB, so it owns the operand and blocks forwarding.
  assign fwd_a_sel = (FWD_EN != 0) && a_hits_wb && !raw_ex;
  assign fwd_b_sel = (FWD_EN != 0) && b_hits_wb && !raw_ex;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller between decode and fetch: RAW stalls, wrong-path squash, deferred interrupts.
// Outputs are combinational from state and inputs (zero-cycle hazard response); stalls hold fetch/decode.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int TYPE_W       = 4,
  parameter int FWD_EN       = 1,
  parameter int BRANCH_FLUSH = 2,
  parameter int CALL_FLUSH   = 2,
  parameter int RETURN_FLUSH = 3,
  parameter int INT_FLUSH    = 2,
  parameter int RESET_FLUSH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] reg_a,
  input  logic [REG_AW-1:0] reg_b,
  input  logic              a_read,
  input  logic              b_read,
  input  logic [REG_AW-1:0] reg_ex,
  input  logic [REG_AW-1:0] reg_wb,
  input  logic              reg_ex_en,
  input  logic              reg_wb_en,
  input  logic [TYPE_W-1:0] instr_type,
  input  logic              branch_taken,
  input  logic              interrupt,
  output logic              imem_addr_mux,
  output logic              fetch_latch_stall,
  output logic              dec_nop,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              pc_reset,
  output logic              pc_mux_override,
  output logic              fwd_a_sel,
  output logic              fwd_b_sel,
  output logic              int_ack,
  output logic              busy
);

  localparam int MAX_FLUSH = max_of(max_of(max_of(BRANCH_FLUSH, CALL_FLUSH),
                                           max_of(RETURN_FLUSH, INT_FLUSH)), RESET_FLUSH);
  localparam int CNT_W = $clog2(MAX_FLUSH + 1);

  localparam logic [CNT_W-1:0] CNT_BRANCH = CNT_W'(BRANCH_FLUSH);
  localparam logic [CNT_W-1:0] CNT_CALL   = CNT_W'(CALL_FLUSH);
  localparam logic [CNT_W-1:0] CNT_RET    = CNT_W'(RETURN_FLUSH - 1);
  localparam logic [CNT_W-1:0] CNT_INT    = CNT_W'(INT_FLUSH);
  localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(RESET_FLUSH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_pending_q, int_pending_d;

  logic raw_ex, raw_wb, fwd_a, fwd_b;
  logic ret, call, int_req, hazard, stall;
  logic nop_c, load_c, override_c, ack_c;

  raw_detect #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_raw_detect (
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .a_read    (a_read),
    .b_read    (b_read),
    .reg_ex    (reg_ex),
    .reg_wb    (reg_wb),
    .reg_ex_en (reg_ex_en),
    .reg_wb_en (reg_wb_en),
    .raw_ex    (raw_ex),
    .raw_wb    (raw_wb),
    .fwd_a_sel (fwd_a),
    .fwd_b_sel (fwd_b)
  );

  assign ret     = (instr_type >= TYPE_W'(TYPE_RET_LO)) && (instr_type <= TYPE_W'(TYPE_RET_HI));
  assign call    = (instr_type == TYPE_W'(TYPE_CALL));
  assign int_req = interrupt || int_pending_q;
  assign hazard  = raw_ex || ((FWD_EN == 0) && raw_wb);
  assign stall   = hazard || (state_q == ST_STALL) || ((state_q == ST_IDLE) && ret);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    int_pending_d = int_pending_q;
    nop_c         = 1'b0;
    load_c        = 1'b0;
    override_c    = 1'b0;
    ack_c         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_req) begin
          ack_c   = 1'b1;
          nop_c   = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_INT;
        end else if (hazard) begin
          nop_c   = 1'b1;
          state_d = ST_STALL;
        end else if (call) begin
          nop_c   = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_CALL;
        end else if (branch_taken && !ret) begin
          load_c  = 1'b1;
          nop_c   = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_BRANCH;
        end else if (ret) begin
          nop_c   = 1'b1;
          state_d = ST_RETURN;
        end
      end
      ST_STALL: begin
        nop_c = 1'b1;
        if (int_req) begin
          ack_c   = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_INT;
        end else if (!hazard) begin
          state_d = ST_IDLE;
        end
      end
      ST_RETURN: begin
        // Redirect cycle: the return address is loaded, remaining bubbles follow in FLUSH.
        load_c     = 1'b1;
        override_c = 1'b1;
        nop_c      = 1'b1;
        state_d    = ST_FLUSH;
        cnt_d      = CNT_RET;
        if (interrupt) int_pending_d = 1'b1;
      end
      default: begin
        nop_c = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_IDLE;
        if (interrupt) int_pending_d = 1'b1;
      end
    endcase
    if (ack_c) int_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FLUSH;
      cnt_q         <= CNT_RESET;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      int_pending_q <= int_pending_d;
    end
  end

  // During reset only pc_reset and dec_nop may be high, whatever the stale state says.
  assign pc_reset          = reset;
  assign dec_nop           = reset || nop_c;
  assign pc_load           = !reset && load_c;
  assign pc_mux_override   = !reset && override_c;
  assign int_ack           = !reset && ack_c;
  assign fetch_latch_stall = !reset && stall;
  assign imem_addr_mux     = !reset && stall;
  assign pc_inc            = !reset && !load_c && !stall;
  assign fwd_a_sel         = !reset && fwd_a;
  assign fwd_b_sel         = !reset && fwd_b;
  assign busy              = !reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: forwarding and non-forwarding instances against a bubble-budget model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW       = 5;
  localparam int TYPE_W       = 4;
  localparam int BRANCH_FLUSH = 2;
  localparam int CALL_FLUSH   = 2;
  localparam int RETURN_FLUSH = 3;
  localparam int INT_FLUSH    = 2;
  localparam int RESET_FLUSH  = 2;

  // Output vector bit positions
  localparam int B_MUX = 10, B_FLS = 9, B_NOP = 8, B_INC = 7, B_LD = 6, B_RST = 5;
  localparam int B_OVR = 4, B_FA = 3, B_FB = 2, B_ACK = 1, B_BSY = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [REG_AW-1:0] reg_a, reg_b, reg_ex, reg_wb;
  logic              a_read, b_read, reg_ex_en, reg_wb_en;
  logic [TYPE_W-1:0] instr_type;
  logic              branch_taken, interrupt;

  logic imem_addr_mux0, fetch_latch_stall0, dec_nop0, pc_inc0, pc_load0, pc_reset0;
  logic pc_mux_override0, fwd_a_sel0, fwd_b_sel0, int_ack0, busy0;
  logic imem_addr_mux1, fetch_latch_stall1, dec_nop1, pc_inc1, pc_load1, pc_reset1;
  logic pc_mux_override1, fwd_a_sel1, fwd_b_sel1, int_ack1, busy1;
  logic [10:0] o0, o1;

  assign o0 = {imem_addr_mux0, fetch_latch_stall0, dec_nop0, pc_inc0, pc_load0, pc_reset0,
               pc_mux_override0, fwd_a_sel0, fwd_b_sel0, int_ack0, busy0};
  assign o1 = {imem_addr_mux1, fetch_latch_stall1, dec_nop1, pc_inc1, pc_load1, pc_reset1,
               pc_mux_override1, fwd_a_sel1, fwd_b_sel1, int_ack1, busy1};

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .TYPE_W(TYPE_W), .FWD_EN(1), .BRANCH_FLUSH(BRANCH_FLUSH),
    .CALL_FLUSH(CALL_FLUSH), .RETURN_FLUSH(RETURN_FLUSH), .INT_FLUSH(INT_FLUSH),
    .RESET_FLUSH(RESET_FLUSH)
  ) u_dut_fwd (
    .clk(clk), .reset(reset), .reg_a(reg_a), .reg_b(reg_b), .a_read(a_read), .b_read(b_read),
    .reg_ex(reg_ex), .reg_wb(reg_wb), .reg_ex_en(reg_ex_en), .reg_wb_en(reg_wb_en),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .imem_addr_mux(imem_addr_mux0), .fetch_latch_stall(fetch_latch_stall0), .dec_nop(dec_nop0),
    .pc_inc(pc_inc0), .pc_load(pc_load0), .pc_reset(pc_reset0),
    .pc_mux_override(pc_mux_override0), .fwd_a_sel(fwd_a_sel0), .fwd_b_sel(fwd_b_sel0),
    .int_ack(int_ack0), .busy(busy0)
  );

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .TYPE_W(TYPE_W), .FWD_EN(0), .BRANCH_FLUSH(BRANCH_FLUSH),
    .CALL_FLUSH(CALL_FLUSH), .RETURN_FLUSH(RETURN_FLUSH), .INT_FLUSH(INT_FLUSH),
    .RESET_FLUSH(RESET_FLUSH)
  ) u_dut_nofwd (
    .clk(clk), .reset(reset), .reg_a(reg_a), .reg_b(reg_b), .a_read(a_read), .b_read(b_read),
    .reg_ex(reg_ex), .reg_wb(reg_wb), .reg_ex_en(reg_ex_en), .reg_wb_en(reg_wb_en),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .imem_addr_mux(imem_addr_mux1), .fetch_latch_stall(fetch_latch_stall1), .dec_nop(dec_nop1),
    .pc_inc(pc_inc1), .pc_load(pc_load1), .pc_reset(pc_reset1),
    .pc_mux_override(pc_mux_override1), .fwd_a_sel(fwd_a_sel1), .fwd_b_sel(fwd_b_sel1),
    .int_ack(int_ack1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Model: bubbles still owed, a pending return redirect, a held stall, a deferred interrupt.
  int m_flush [2];
  bit m_redir [2];
  bit m_stall [2];
  bit m_pend  [2];

  task automatic model_step(input int k, output logic [10:0] e);
    bit fe, rex, rwb, haz, is_ret, is_call, intr, idle, was_stall, st;
    bit nop, ld, ovr, ack, fa, fb;
    e = '0;
    if (reset) begin
      e[B_NOP] = 1'b1;
      e[B_RST] = 1'b1;
      m_flush[k] = RESET_FLUSH;
      m_redir[k] = 1'b0;
      m_stall[k] = 1'b0;
      m_pend[k]  = 1'b0;
      return;
    end
    fe      = (k == 0);
    rex     = reg_ex_en && ((a_read && reg_a == reg_ex) || (b_read && reg_b == reg_ex));
    rwb     = reg_wb_en && ((a_read && reg_a == reg_wb) || (b_read && reg_b == reg_wb));
    haz     = rex || (!fe && rwb);
    is_ret  = (int'(instr_type) >= 7) && (int'(instr_type) <= 9);
    is_call = (int'(instr_type) == 6);
    intr    = interrupt || m_pend[k];
    idle    = (m_flush[k] == 0) && !m_redir[k] && !m_stall[k];
    was_stall = m_stall[k];
    nop = 0; ld = 0; ovr = 0; ack = 0;
    if (m_redir[k]) begin
      ld = 1; ovr = 1; nop = 1;
      if (interrupt) m_pend[k] = 1'b1;
      m_redir[k] = 1'b0;
      m_flush[k] = RETURN_FLUSH - 1;
    end else if (m_flush[k] > 0) begin
      nop = 1;
      if (interrupt) m_pend[k] = 1'b1;
      m_flush[k] = m_flush[k] - 1;
    end else if (m_stall[k]) begin
      nop = 1;
      if (intr) begin
        ack = 1; m_stall[k] = 1'b0; m_flush[k] = INT_FLUSH;
      end else begin
        m_stall[k] = haz;
      end
    end else if (intr) begin
      ack = 1; nop = 1; m_flush[k] = INT_FLUSH;
    end else if (haz) begin
      nop = 1; m_stall[k] = 1'b1;
    end else if (is_call) begin
      nop = 1; m_flush[k] = CALL_FLUSH;
    end else if (branch_taken && !is_ret) begin
      ld = 1; nop = 1; m_flush[k] = BRANCH_FLUSH;
    end else if (is_ret) begin
      nop = 1; m_redir[k] = 1'b1;
    end
    if (ack) m_pend[k] = 1'b0;
    st = haz || was_stall || (idle && is_ret);
    fa = fe && a_read && reg_wb_en && (reg_a == reg_wb) && !rex;
    fb = fe && b_read && reg_wb_en && (reg_b == reg_wb) && !rex;
    e = {st, st, nop, (!ld && !st), ld, 1'b0, ovr, fa, fb, ack, !idle};
  endtask

  task automatic sample();
    logic [10:0] e;
    @(negedge clk);
    model_step(0, e);
    check_eq("fwd_outputs", int'(o0), int'(e));
    model_step(1, e);
    check_eq("nofwd_outputs", int'(o1), int'(e));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; reg_a = '0; reg_b = '0; reg_ex = '0; reg_wb = '0;
    a_read = 0; b_read = 0; reg_ex_en = 0; reg_wb_en = 0;
    instr_type = '0; branch_taken = 0; interrupt = 0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle(); clear_inputs(); sample();
    end
  endtask

  int nops;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0; m_redir[k] = 0; m_stall[k] = 0; m_pend[k] = 0;
    end
    clear_inputs();

    // Reset for one cycle, then the reset flush
    reset = 1; sample();
    check_eq("rst_pc_reset", int'(pc_reset0), 1);
    check_eq("rst_dec_nop", int'(dec_nop0), 1);
    check_eq("rst_pc_inc", int'(pc_inc0), 0);
    check_eq("rst_busy", int'(busy0), 0);
    for (int i = 0; i < RESET_FLUSH; i++) begin
      next_cycle(); clear_inputs(); sample();
      check_eq("rstflush_nop", int'(dec_nop0), 1);
      check_eq("rstflush_pc_reset", int'(pc_reset0), 0);
    end
    next_cycle(); clear_inputs(); sample();
    check_eq("post_rst_pc_inc", int'(pc_inc0), 1);
    check_eq("post_rst_nop", int'(dec_nop0), 0);

    // RAW against EX, then forwarding from WB
    next_cycle(); reg_a = 5'd3; a_read = 1; reg_ex = 5'd3; reg_ex_en = 1; sample();
    check_eq("rawex_stall", int'(fetch_latch_stall0), 1);
    check_eq("rawex_nop", int'(dec_nop0), 1);
    check_eq("rawex_inc", int'(pc_inc0), 0);
    next_cycle(); reg_ex_en = 0; sample();
    check_eq("rawex_stall2", int'(fetch_latch_stall0), 1);
    next_cycle(); reg_wb = 5'd3; reg_wb_en = 1; sample();
    check_eq("fwd_a_sel", int'(fwd_a_sel0), 1);
    check_eq("fwd_no_stall", int'(fetch_latch_stall0), 0);
    check_eq("nofwd_wb_stall", int'(fetch_latch_stall1), 1);
    quiet(2);

    // WB hazard on B: forwarded in one instance, stalled in the other
    next_cycle(); reg_b = 5'd7; b_read = 1; reg_wb = 5'd7; reg_wb_en = 1; sample();
    check_eq("nofwd_b_stall", int'(fetch_latch_stall1), 1);
    check_eq("nofwd_b_nop", int'(dec_nop1), 1);
    check_eq("nofwd_b_fwd", int'(fwd_b_sel1), 0);
    check_eq("fwd_b_sel", int'(fwd_b_sel0), 1);
    quiet(2);

    // Taken branch
    next_cycle(); branch_taken = 1; sample();
    check_eq("br_pc_load", int'(pc_load0), 1);
    check_eq("br_inc", int'(pc_inc0), 0);
    for (int i = 0; i < BRANCH_FLUSH; i++) begin
      next_cycle(); clear_inputs(); sample();
      check_eq("br_bubble", int'(dec_nop0), 1);
      check_eq("br_bubble_ld", int'(pc_load0), 0);
    end
    next_cycle(); clear_inputs(); sample();
    check_eq("br_done_busy", int'(busy0), 0);

    // Return: detect, redirect, then the remaining bubbles
    nops = 0;
    next_cycle(); instr_type = 4'd8; sample();
    check_eq("ret_stall", int'(fetch_latch_stall0), 1);
    nops += int'(dec_nop0);
    next_cycle(); clear_inputs(); sample();
    check_eq("ret_load", int'(pc_load0), 1);
    check_eq("ret_override", int'(pc_mux_override0), 1);
    nops += int'(dec_nop0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); clear_inputs(); sample();
      nops += int'(dec_nop0);
    end
    check_eq("ret_nop_total", nops, 1 + RETURN_FLUSH);

    // Interrupt during the return redirect is deferred to IDLE
    next_cycle(); instr_type = 4'd8; sample();
    next_cycle(); clear_inputs(); interrupt = 1; sample();
    check_eq("defer_no_ack", int'(int_ack0), 0);
    for (int i = 0; i < RETURN_FLUSH - 1; i++) begin
      next_cycle(); clear_inputs(); sample();
      check_eq("defer_flush_no_ack", int'(int_ack0), 0);
    end
    next_cycle(); clear_inputs(); sample();
    check_eq("defer_ack", int'(int_ack0), 1);
    check_eq("defer_ack_nop", int'(dec_nop0), 1);
    for (int i = 0; i < INT_FLUSH; i++) begin
      next_cycle(); clear_inputs(); sample();
      check_eq("int_bubble", int'(dec_nop0), 1);
    end
    next_cycle(); clear_inputs(); sample();
    check_eq("int_done_nop", int'(dec_nop0), 0);

    // Interrupt beats a simultaneous taken branch
    next_cycle(); interrupt = 1; branch_taken = 1; sample();
    check_eq("intbr_ack", int'(int_ack0), 1);
    check_eq("intbr_no_load", int'(pc_load0), 0);
    quiet(3);

    // Reset mid-return drops the deferred interrupt
    next_cycle(); instr_type = 4'd7; sample();
    next_cycle(); clear_inputs(); interrupt = 1; sample();
    next_cycle(); clear_inputs(); reset = 1; sample();
    check_eq("midrst_pc_reset", int'(pc_reset0), 1);
    check_eq("midrst_no_load", int'(pc_load0), 0);
    quiet(RESET_FLUSH);
    next_cycle(); clear_inputs(); sample();
    check_eq("midrst_pend_cleared", int'(int_ack0), 0);

    // Call
    next_cycle(); instr_type = 4'd6; sample();
    check_eq("call_nop", int'(dec_nop0), 1);
    quiet(CALL_FLUSH + 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      reset        = ($urandom_range(99) < 2);
      reg_a        = REG_AW'($urandom_range(3));
      reg_b        = REG_AW'($urandom_range(3));
      reg_ex       = REG_AW'($urandom_range(3));
      reg_wb       = REG_AW'($urandom_range(3));
      a_read       = ($urandom_range(1) == 1);
      b_read       = ($urandom_range(2) == 0);
      reg_ex_en    = ($urandom_range(2) == 0);
      reg_wb_en    = ($urandom_range(1) == 1);
      instr_type   = TYPE_W'($urandom_range(15));
      branch_taken = ($urandom_range(9) < 2);
      interrupt    = ($urandom_range(19) == 0);
      sample();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and flush controller for the pipelined RAT core. It sits between decode and fetch. It detects read-after-write hazards against the EX and WB stages, and it squashes wrong-path instructions after calls, taken branches, returns, interrupts and reset. It differs from the first-generation controller in four ways: configurable flush depths, optional WB-to-decode forwarding, deferred interrupts with an acknowledge pulse, and a counter-based flush.

## Interface
- `REG_AW`, 5: register-address width.
- `TYPE_W`, 4: `instr_type` width.
- `FWD_EN`, 1: 1 = WB hazards are forwarded; 0 = WB hazards stall.
- `BRANCH_FLUSH`, 2: bubbles after a taken branch (≥1).
- `CALL_FLUSH`, 2: bubbles after a call (≥1).
- `RETURN_FLUSH`, 3: bubbles after a return, including the redirect cycle (≥2).
- `INT_FLUSH`, 2: bubbles after an interrupt is taken (≥1).
- `RESET_FLUSH`, 2: bubbles after reset deasserts (≥1).

Ports:
- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `reg_a`, `reg_b` in REG_AW: decode source registers.
- `a_read`, `b_read` in 1: the source is actually read.
- `reg_ex`, `reg_wb` in REG_AW: destination register in EX / WB.
- `reg_ex_en`, `reg_wb_en` in 1: that destination is written.
- `instr_type` in TYPE_W: decode class (1–5 branch, 6 call, 7–9 return).
- `branch_taken` in 1: EX resolved a taken branch.
- `interrupt` in 1: interrupt request (level or pulse).
- `imem_addr_mux` out 1: selects the held fetch address.
- `fetch_latch_stall` out 1: hold the fetch/decode latch.
- `dec_nop` out 1: inject a bubble into decode.
- `pc_inc`, `pc_load`, `pc_reset` out 1: PC controls.
- `pc_mux_override` out 1: PC source = return address.
- `fwd_a_sel`, `fwd_b_sel` out 1: operand from the WB result.
- `int_ack` out 1: one-cycle pulse when an interrupt is taken.
- `busy` out 1: state ≠ IDLE.

## Operation
- Hazard terms:
  - `raw_ex` = reg_ex_en & ((a_read & reg_a==reg_ex) | (b_read & reg_b==reg_ex)).
  - `raw_wb` is the same expression using the WB fields.
  - `ret` = instr_type ∈ {7,8,9}.
- Forwarding: `fwd_x_sel` = FWD_EN & x_read & reg_wb_en & reg_x==reg_wb & !raw_ex.
- States are IDLE, STALL, RETURN, FLUSH. The flush counter `cnt` is ⌈log2(max flush+1)⌉ bits wide.
- `stall` = raw_ex | state==STALL | (!FWD_EN & raw_wb) | (state==IDLE & ret). The following outputs equal `stall`: fetch_latch_stall, imem_addr_mux.
- PC controls:
  - `pc_inc` = !reset & !pc_load & !stall.
  - `pc_reset` = reset.
- IDLE is evaluated in the following priority order (first match wins):
  1. take interrupt (`interrupt` or `int_pending`): int_ack=1, dec_nop=1; go to FLUSH with cnt=INT_FLUSH.
  2. `raw_ex`, or `raw_wb` with !FWD_EN: dec_nop=1; go to STALL.
  3. call: dec_nop=1; go to FLUSH with cnt=CALL_FLUSH.
  4. branch_taken & !ret: pc_load=1, dec_nop=1; go to FLUSH with cnt=BRANCH_FLUSH.
  5. ret: dec_nop=1; go to RETURN.
  6. otherwise stay in IDLE; all outputs 0 except pc_inc=1.
- STALL: dec_nop=1.
  - Interrupt preempts: int_ack=1; go to FLUSH with INT_FLUSH.
  - Otherwise re-evaluate the hazard: if it persists, stay in STALL; if not, go to IDLE.
- RETURN: pc_load=1, pc_mux_override=1, dec_nop=1; go to FLUSH with cnt=RETURN_FLUSH−1.
- FLUSH: dec_nop=1.
  - cnt decrements each cycle.
  - When cnt==1, go to IDLE next cycle.
- Deferred interrupt:
  - In RETURN or FLUSH, an interrupt sets `int_pending` and is not acked.
  - `int_pending` clears on int_ack.
  - The deferred interrupt is taken in the first IDLE cycle.

## Timing
- All outputs are combinational from registered state and current inputs. Hazard response has zero-cycle latency.
- Reset cycle: pc_reset=1, dec_nop=1; every other output is 0. Registers load state=FLUSH, cnt=RESET_FLUSH, int_pending=0.
- Bubble count after each event:
  - Branch, call, interrupt: exactly N bubbles following the detection cycle (N is the matching flush parameter).
  - Return: 1 detect cycle + RETURN_FLUSH cycles.
- Reset asserted mid-sequence aborts the sequence immediately and clears pending interrupts.
- Simultaneous interrupt and branch_taken in IDLE: the interrupt wins; pc_load is not asserted.
- pc_load and pc_inc are never both 1.

## Structure
- Package `pipeline_pkg` holds:
  - `instr_type` constants: TYPE_BRANCH_LO=1, TYPE_BRANCH_HI=5, TYPE_CALL=6, TYPE_RET_LO=7, TYPE_RET_HI=9.
  - The `hazard_state_t` enum.
- One sub-module, `raw_detect`: a parametrised comparator returning raw_ex, raw_wb and the forward selects.

## Test plan
- reset held 1 cycle, then released → pc_reset=1 for 1 cycle, then dec_nop=1 for 2 cycles, then pc_inc=1.
- reg_a=3, a_read=1, reg_ex=3, reg_ex_en=1 for 1 cycle → 2 cycles of stall. With FWD_EN=1, the following cycle (reg_wb=3) gives fwd_a_sel=1 and no stall.
- branch_taken=1 in IDLE, BRANCH_FLUSH=2 → pc_load for 1 cycle, then 2 bubbles, then IDLE.
- instr_type=8 → stall+nop, then pc_load & pc_mux_override, then 2 bubbles; total 4 nop cycles.
- interrupt pulse during the RETURN state → no int_ack until IDLE, then int_ack=1 and 2 more bubbles.
- FWD_EN=0, reg_b=7, b_read=1, reg_wb=7, reg_wb_en=1 → stall and dec_nop; fwd_b_sel=0.
